// File: rtl/layer2_sequencer_pkg.sv
// Shared definitions for the Layer 2 sequencer: default sizing and FSM state encoding.
package layer2_sequencer_pkg;

  localparam int unsigned DefNodes     = 100;
  localparam int unsigned DefIndexW    = 7;
  localparam int unsigned DefValW      = 16;
  localparam int unsigned DefWeightLat = 2;

  // 3-bit state encoding, kept as plain constants for older tools.
  typedef logic [2:0] seqState_t;

  localparam seqState_t StIdle  = 3'd0;
  localparam seqState_t StLoad  = 3'd1;
  localparam seqState_t StDeq   = 3'd2;
  localparam seqState_t StCap   = 3'd3;
  localparam seqState_t StFetch = 3'd4;
  localparam seqState_t StIssue = 3'd5;
  localparam seqState_t StDone  = 3'd6;

endpackage

// File: rtl/layer2_seq_latency_timer.sv
// Loadable down-counter that times the weight storage read latency.
// expired is high once WEIGHT_LAT cycles have elapsed since the load cycle's edge.
module layer2_seq_latency_timer #(
  parameter int unsigned WEIGHT_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int unsigned CntW = (WEIGHT_LAT > 1) ? $clog2(WEIGHT_LAT) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(WEIGHT_LAT - 1);

  logic [CntW-1:0] count;

  // Count down from WEIGHT_LAT-1 to zero, holding at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LoadVal;
    end else if (count != '0) begin
      count <= count - CntW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/layer2_sequencer.sv
// Layer 2 sequencer: drains the Layer 1 ReLU node queue, requests each node's weight row
// and issues (index, value) operations to the multiply-store unit under valid/ready.
// Optional feature: define LAYER2_SEQ_ZERO_SKIP_EN to skip nodes whose ReLU value is zero.
module layer2_sequencer
  import layer2_sequencer_pkg::*;
#(
  parameter int unsigned NODES      = DefNodes,
  parameter int unsigned INDEX_W    = DefIndexW,
  parameter int unsigned VAL_W      = DefValW,
  parameter int unsigned WEIGHT_LAT = DefWeightLat
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               qWriteEnable,
  output logic               qDequeue,
  input  logic [INDEX_W-1:0] qIndex,
  input  logic [VAL_W-1:0]   qValue,
  input  logic               qEmpty,
  output logic [INDEX_W-1:0] wAddr,
  output logic               wRead,
  output logic               macValid,
  input  logic               macReady,
  output logic [INDEX_W-1:0] macIndex,
  output logic [VAL_W-1:0]   macValue,
  output logic               busy,
  output logic               done,
  output logic               seqError
);

  // One extra bit so the node count compare cannot alias.
  localparam logic [INDEX_W:0] NodesW = (INDEX_W+1)'(NODES);

  seqState_t          state, stateD;
  logic [INDEX_W-1:0] curIdx, issued;
  logic [VAL_W-1:0]   curVal;
  logic [INDEX_W:0]   issuedNext;
  logic               lastNode, isZero, timerExpired, errSet;

  assign issuedNext = {1'b0, issued} + (INDEX_W+1)'(1);
  assign lastNode   = (issuedNext == NodesW);

`ifdef LAYER2_SEQ_ZERO_SKIP_EN
  assign isZero = (qValue == '0);
`else
  assign isZero = 1'b0;
`endif

  layer2_seq_latency_timer #(
    .WEIGHT_LAT(WEIGHT_LAT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state == StCap),
    .expired(timerExpired)
  );

  // Next-state decode.
  always_comb begin
    stateD = state;
    unique case (state)
      StIdle:  if (start) stateD = StLoad;
      StLoad:  stateD = StDeq;
      StDeq:   stateD = StCap;
      StCap: begin
        if (isZero) stateD = lastNode ? StDone : StDeq;
        else        stateD = StFetch;
      end
      StFetch: if (timerExpired) stateD = StIssue;
      StIssue: if (macReady) stateD = lastNode ? StDone : StDeq;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Queue must be non-empty while nodes remain, and empty when the run finishes.
  always_comb begin
    errSet = 1'b0;
    if (state == StDeq && ({1'b0, issued} < NodesW) && qEmpty) errSet = 1'b1;
    if (stateD == StDone && state != StDone && !qEmpty)        errSet = 1'b1;
  end

  // State, datapath registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      issued       <= '0;
      curIdx       <= '0;
      curVal       <= '0;
      qWriteEnable <= 1'b0;
      qDequeue     <= 1'b0;
      wRead        <= 1'b0;
      macValid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      seqError     <= 1'b0;
    end else begin
      state <= stateD;
      if (state == StLoad) begin
        issued <= '0;
      end else if ((state == StIssue && macReady) || (state == StCap && isZero)) begin
        issued <= issuedNext[INDEX_W-1:0];
      end
      if (state == StCap) begin
        curIdx <= qIndex;
        curVal <= qValue;
      end
      qWriteEnable <= (stateD == StLoad);
      qDequeue     <= (stateD == StDeq);
      wRead        <= (stateD == StFetch) && (state != StFetch);
      macValid     <= (stateD == StIssue);
      busy         <= (stateD != StIdle);
      done         <= (stateD == StDone);
      seqError     <= seqError | errSet;
    end
  end

  // Address and operation fields only change in CAP, so they stay stable through stalls.
  assign wAddr    = curIdx;
  assign macIndex = curIdx;
  assign macValue = curVal;

endmodule

// File: tb/tb_layer2_sequencer.sv
// Self-checking bench for layer2_sequencer: queue and multiplier models, directed scenarios
// with randomized node values, checked against a per-run reference computed from node values.
module tb_layer2_sequencer;

  localparam int unsigned NODES      = 4;
  localparam int unsigned INDEX_W    = 7;
  localparam int unsigned VAL_W      = 16;
  localparam int unsigned WEIGHT_LAT = 2;

`ifdef LAYER2_SEQ_ZERO_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startMain = 1'b0;
  logic               startExtra = 1'b0;
  logic               start;
  logic               qWriteEnable, qDequeue, qEmpty;
  logic [INDEX_W-1:0] qIndex, wAddr, macIndex;
  logic [VAL_W-1:0]   qValue, macValue;
  logic               wRead, macValid, busy, done, seqError;
  logic               macReady = 1'b1;

  int total = 0;
  int bad   = 0;

  assign start = startMain | startExtra;

  always #5 clk = ~clk;

  layer2_sequencer #(
    .NODES     (NODES),
    .INDEX_W   (INDEX_W),
    .VAL_W     (VAL_W),
    .WEIGHT_LAT(WEIGHT_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .qWriteEnable(qWriteEnable),
    .qDequeue    (qDequeue),
    .qIndex      (qIndex),
    .qValue      (qValue),
    .qEmpty      (qEmpty),
    .wAddr       (wAddr),
    .wRead       (wRead),
    .macValid    (macValid),
    .macReady    (macReady),
    .macIndex    (macIndex),
    .macValue    (macValue),
    .busy        (busy),
    .done        (done),
    .seqError    (seqError)
  );

  // Node queue model: loaded on qWriteEnable, pops to its output register on qDequeue.
  logic [INDEX_W-1:0] stageIdx [NODES];
  logic [VAL_W-1:0]   stageVal [NODES];
  logic [INDEX_W-1:0] memIdx   [NODES];
  logic [VAL_W-1:0]   memVal   [NODES];
  logic [INDEX_W-1:0] outIdx = '0;
  logic [VAL_W-1:0]   outVal = '0;
  int                 head = int'(NODES);
  logic               forceEmpty = 1'b0;

  always @(posedge clk) begin
    if (qWriteEnable) begin
      for (int i = 0; i < int'(NODES); i++) begin
        memIdx[i] <= stageIdx[i];
        memVal[i] <= stageVal[i];
      end
      head <= 0;
    end else if (qDequeue && head < int'(NODES)) begin
      outIdx <= memIdx[head];
      outVal <= memVal[head];
      head   <= head + 1;
    end
  end

  assign qIndex = outIdx;
  assign qValue = outVal;
  assign qEmpty = forceEmpty || (head >= int'(NODES));

  // Multiplier model and event logging, all on the falling edge.
  int                 stallIdx = -1;
  int                 stallLen = 0;
  int                 stallCnt = 0;
  int                 forceDeqNum = -1;
  bit                 extraStartReq = 1'b0;
  int                 deqCnt = 0;
  int                 deqBackToBack = 0;
  int                 deqDuringStall = 0;
  int                 idxChange = 0;
  bit                 prevDeq = 1'b0;
  logic [INDEX_W-1:0] heldIdx = '0;
  logic [INDEX_W-1:0] hsIdx [$];
  logic [VAL_W-1:0]   hsVal [$];
  logic [INDEX_W-1:0] rdAddr [$];

  always @(negedge clk) begin
    if (!macReady && qDequeue) deqDuringStall++;
    if (!macReady && macIndex != heldIdx) idxChange++;
    if (macValid && int'(macIndex) == stallIdx && stallCnt < stallLen) begin
      macReady = 1'b0;
      heldIdx  = macIndex;
      stallCnt++;
    end else begin
      macReady = 1'b1;
    end
    if (macValid && macReady) begin
      hsIdx.push_back(macIndex);
      hsVal.push_back(macValue);
    end
    if (wRead) rdAddr.push_back(wAddr);
    if (qDequeue) begin
      if (prevDeq) deqBackToBack++;
      forceEmpty = (deqCnt == forceDeqNum);
      deqCnt++;
    end else begin
      forceEmpty = 1'b0;
    end
    prevDeq = qDequeue;
    if (extraStartReq && macValid) begin
      startExtra    = 1'b1;
      extraStartReq = 1'b0;
    end else begin
      startExtra = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    check(tag, 64'({qWriteEnable, qDequeue, wRead, macValid, busy, done, seqError,
                    wAddr, macIndex, macValue}), 64'd0);
  endtask

  task automatic setVals(input bit randIdx, input bit randVal);
    for (int i = 0; i < int'(NODES); i++) begin
      stageIdx[i] = randIdx ? INDEX_W'($urandom_range(0, 127)) : INDEX_W'(i);
      if (randVal) begin
        stageVal[i] = ($urandom_range(0, 3) == 0) ? '0 : VAL_W'($urandom_range(1, 65535));
      end
    end
  endtask

  // Launch one run and compare against what the node values say must happen.
  task automatic runCheck(input string tag, input bit expErr);
    int                 n;
    int                 expCycles;
    logic [INDEX_W-1:0] eIdx [$];
    logic [VAL_W-1:0]   eVal [$];
    expCycles = 2;
    for (int i = 0; i < int'(NODES); i++) begin
      if (SkipEn && stageVal[i] == '0) begin
        expCycles += 2;
      end else begin
        expCycles += 3 + int'(WEIGHT_LAT);
        eIdx.push_back(stageIdx[i]);
        eVal.push_back(stageVal[i]);
        if (int'(stageIdx[i]) == stallIdx) expCycles += stallLen;
      end
    end
    hsIdx.delete();
    hsVal.delete();
    rdAddr.delete();
    deqCnt = 0;
    deqBackToBack = 0;
    deqDuringStall = 0;
    idxChange = 0;
    stallCnt = 0;

    startMain = 1'b1;
    @(negedge clk);
    startMain = 1'b0;
    check({tag, ".busyRise"}, 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(expCycles));
    check({tag, ".busyInDone"}, 64'(busy), 64'd1);
    check({tag, ".hsCount"}, 64'(hsIdx.size()), 64'(eIdx.size()));
    for (int i = 0; i < eIdx.size() && i < hsIdx.size(); i++) begin
      check($sformatf("%s.hsIdx%0d", tag, i), 64'(hsIdx[i]), 64'(eIdx[i]));
      check($sformatf("%s.hsVal%0d", tag, i), 64'(hsVal[i]), 64'(eVal[i]));
    end
    check({tag, ".wReadCount"}, 64'(rdAddr.size()), 64'(eIdx.size()));
    for (int i = 0; i < eIdx.size() && i < rdAddr.size(); i++) begin
      check($sformatf("%s.wAddr%0d", tag, i), 64'(rdAddr[i]), 64'(eIdx[i]));
    end
    check({tag, ".deqCount"}, 64'(deqCnt), 64'(NODES));
    check({tag, ".deqBackToBack"}, 64'(deqBackToBack), 64'd0);
    check({tag, ".deqDuringStall"}, 64'(deqDuringStall), 64'd0);
    check({tag, ".idxHeld"}, 64'(idxChange), 64'd0);
    check({tag, ".seqError"}, 64'(seqError), 64'(expErr));
    @(negedge clk);
    check({tag, ".donePulse"}, 64'(done), 64'd0);
    check({tag, ".busyIdle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutputsZero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic run with the reference values.
    stageVal[0] = 16'd5;
    stageVal[1] = 16'd0;
    stageVal[2] = 16'd7;
    stageVal[3] = 16'd3;
    setVals(1'b0, 1'b0);
    runCheck("basic", 1'b0);

    // Ten-cycle backpressure on node index 2.
    setVals(1'b0, 1'b1);
    if (stageVal[2] == '0) stageVal[2] = 16'd11;
    stallIdx = 2;
    stallLen = 10;
    runCheck("stall", 1'b0);
    stallIdx = -1;
    stallLen = 0;

    // Randomized indices and values.
    for (int r = 0; r < 5; r++) begin
      setVals(1'b1, 1'b1);
      runCheck($sformatf("rand%0d", r), 1'b0);
    end

    // Reset during FETCH of node 1, then replay from the start.
    setVals(1'b0, 1'b0);
    stageVal[0] = 16'd9;
    stageVal[1] = 16'd4;
    stageVal[2] = 16'd2;
    stageVal[3] = 16'd8;
    startMain = 1'b1;
    @(negedge clk);
    startMain = 1'b0;
    n = 0;
    while (!(wRead && wAddr == stageIdx[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midReset.reachFetch", 64'(n < 200), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutputsZero("midReset.outputs");
    reset = 1'b0;
    @(negedge clk);
    runCheck("replay", 1'b0);

    // A start pulse during ISSUE must be ignored.
    setVals(1'b1, 1'b1);
    stageVal[0] = 16'd21;
    extraStartReq = 1'b1;
    runCheck("startIgnored", 1'b0);
    extraStartReq = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("startIgnored.stayIdle", 64'(busy), 64'd0);

    // Queue reports empty on the second dequeue: sticky error until reset.
    setVals(1'b0, 1'b1);
    forceDeqNum = 1;
    runCheck("seqErr", 1'b1);
    forceDeqNum = -1;
    @(negedge clk);
    check("seqErr.sticky", 64'(seqError), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutputsZero("seqErr.cleared");
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer2_sequencer.md
# layer2_sequencer

Controller that drains the Layer 1 ReLU node queue into the Layer 2 multiply-store datapath. On a start pulse it loads the queue, then repeatedly dequeues one node, requests that node's weight row from Layer 2 weight storage, and issues a (index, value) operation to the multiplier under a valid/ready handshake. It pulses done after every node has been issued. It sits between the Layer 1 output stage, the node queue, the Layer 2 weight storage and the multiply-store unit.

## Interface
- Parameters:
- `NODES`, default 100: ReLU node count, at least 1.
- `INDEX_W`, default 7: node index width. Must satisfy `INDEX_W` ≥ clog2(`NODES`+1).
- `VAL_W`, default 16: node value width.
- `WEIGHT_LAT`, default 2: weight storage read latency in cycles, at least 1.
- Ports (clock is `clk`; reset is `reset`, synchronous, active-high):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle pulse; Layer 1 outputs are valid.
- `qWriteEnable`  out  1  queue load strobe.
- `qDequeue`  out  1  queue dequeue strobe.
- `qIndex`  in  `INDEX_W`  queue index output.
- `qValue`  in  `VAL_W`  queue value output.
- `qEmpty`  in  1  queue empty flag.
- `wAddr`  out  `INDEX_W`  weight row address.
- `wRead`  out  1  weight read request, one cycle.
- `macValid`  out  1  operation valid.
- `macReady`  in  1  multiplier accepts.
- `macIndex`  out  `INDEX_W`  node index of the operation.
- `macValue`  out  `VAL_W`  node value of the operation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last operation is accepted.
- `seqError`  out  1  sticky; the issue count disagrees with `qEmpty`.

## Operation
- FSM states: IDLE, LOAD, DEQ, CAP, FETCH, ISSUE, DONE.
- IDLE:
  - On `start` go to LOAD.
  - Otherwise `start` is ignored; a `start` in any other state is also ignored.
- LOAD:
  - `qWriteEnable`=1 for one cycle; clear `issued` counter.
  - Next state: DEQ.
- DEQ: `qDequeue`=1 for one cycle, which gives the queue its rising edge. Next state: CAP.
- CAP:
  - `qDequeue`=0; register `qIndex`/`qValue` into `curIdx`/`curVal`.
  - Next state: FETCH.
- FETCH:
  - `wAddr`=`curIdx`; `wRead`=1 in the first cycle only.
  - Wait `WEIGHT_LAT` cycles, then go to ISSUE.
- ISSUE:
  - `macValid`=1 with `macIndex`/`macValue` held stable until `macReady`.
  - On the handshake, increment `issued`.
  - If `issued`+1 == `NODES`, go to DONE. Otherwise go to DEQ.
- DONE: `done`=1 for one cycle. Next state: IDLE.
- Error check: in any cycle entering DONE, `qEmpty` must be 1. In any DEQ with `issued` < `NODES`, `qEmpty` must be 0. Any violation sets `seqError`; only `reset` clears it.
- `issued` width: `INDEX_W`; it never wraps because it terminates at `NODES`.

## Timing
- Reset: `reset` sampled high forces IDLE in any state, including mid-operation. On the next edge:
  - `qWriteEnable`, `qDequeue`, `wRead`, `macValid`, `busy`, `done`, `seqError` = 0.
  - `wAddr`, `macIndex`, `macValue`, `curIdx`, `curVal`, `issued` = 0.
- Outputs are registered. `busy` rises the cycle after `start`.
- Per-node latency with `macReady` tied high: 3 + `WEIGHT_LAT` cycles (DEQ, CAP, FETCH×`WEIGHT_LAT`, ISSUE).
- Total with `macReady` tied high: 1 + `NODES`·(3+`WEIGHT_LAT`) + 1 cycles from `start` to `done`.
- `macReady` low stalls in ISSUE indefinitely; the queue is not touched during a stall.
- `qDequeue` is never high in two consecutive cycles; there is at least one low cycle for the queue's pointer update.
- `NODES`=1: a single iteration, then DONE.

## Configuration
- `LAYER2_SEQ_ZERO_SKIP_EN` defined:
  - In CAP, if `qValue`==0, skip FETCH/ISSUE; count the node as issued.
  - Go to DEQ, or to DONE if it was the last node.
  - ReLU zeros cost 2 cycles each and produce no `wRead` or `macValid`.
- Undefined: every node is fetched and issued regardless of value.

## Structure
- Shared package holds the FSM state enum (3-bit encoding) and localparams for default `NODES`/`INDEX_W`/`VAL_W`, consistent with the global variables.
- One sub-module, `layer2_seq_latency_timer`: a loadable down-counter for FETCH wait. Inputs: `load`, `WEIGHT_LAT`. Output: `expired`.

## Test plan
- **Basic run:** `NODES`=4, `WEIGHT_LAT`=2, values {5,0,7,3}, `macReady`=1, skip off:
  - 4 handshakes with indices 0..3 and values 5,0,7,3.
  - `done` exactly 22 cycles after `start`.
- **Backpressure:** `macReady` low 10 cycles on node 2 → `macIndex`=2 held stable; no `qDequeue` during the stall; total delayed by 10.
- **Zero skip:** same values as the basic run, with `LAYER2_SEQ_ZERO_SKIP_EN` defined:
  - Exactly 3 handshakes (indices 0,2,3); no `wRead` for index 1.
  - `done` 19 cycles after `start`.
- **Reset mid-run:** assert `reset` during FETCH of node 1:
  - All outputs 0 next cycle; state IDLE.
  - A new `start` replays from index 0.
- **Error flag:** force `qEmpty`=1 during the second DEQ → `seqError`=1 and it remains set through `done` until `reset`.
- **Start ignored:** `start` pulsed during ISSUE → no restart; the run completes normally.
